// File: rtl/riscv_pkg.sv
// Shared RV32I decode/ALU types: operation encodings, opcodes, operand selects
// and the control bundle handed from decode to EX.
package riscv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_XOR = 4'd2, ALU_OR  = 4'd3, ALU_AND = 4'd4,
        ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_NOP = 4'd8
    } alu_op_t;

    typedef enum logic [2:0] {
        CMP_EQ = 3'd0, CMP_NEQ = 3'd1, CMP_LT = 3'd2, CMP_GE = 3'd3, CMP_LTU = 3'd4, CMP_GEU = 3'd5
    } cmp_op_t;

    typedef enum logic [1:0] {SRC_A_RS1 = 2'd0, SRC_A_PC = 2'd1, SRC_A_ZERO = 2'd2} src_a_t;
    typedef enum logic [1:0] {SRC_B_RS2 = 2'd0, SRC_B_IMM = 2'd1, SRC_B_FOUR = 2'd2} src_b_t;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
    } imm_fmt_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        alu_op_t          alu_ctrl;
        cmp_op_t          cmp_ctrl;
        src_a_t           src_a_sel;
        src_b_t           src_b_sel;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  imm;
        logic             reg_we;
        logic             cmp_to_rd;
        logic             mem_re;
        logic             mem_we;
        logic [2:0]       mem_funct3;
        logic             is_branch;
        logic             is_jal;
        logic             is_jalr;
        logic             illegal;
    } decode_bundle_t;

    typedef struct packed {
        alu_op_t alu;
        cmp_op_t cmp;
        logic    cmp_to_rd;
    } arith_t;

    // funct3 map shared by OP and OP-IMM; alt selects SUB/SRA
    function automatic arith_t arith_map(input logic [2:0] funct3, input logic alt);
        arith_t r;
        r.alu       = ALU_NOP;
        r.cmp       = CMP_EQ;
        r.cmp_to_rd = 1'b0;
        case (funct3)
            3'b000:  r.alu = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r.alu = ALU_SLL;
            3'b010:  begin r.cmp = CMP_LT;  r.cmp_to_rd = 1'b1; end
            3'b011:  begin r.cmp = CMP_LTU; r.cmp_to_rd = 1'b1; end
            3'b100:  r.alu = ALU_XOR;
            3'b101:  r.alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r.alu = ALU_OR;
            default: r.alu = ALU_AND;
        endcase
        return r;
    endfunction

    function automatic decode_bundle_t reset_bundle();
        decode_bundle_t b;
        b          = '0;
        b.alu_ctrl = ALU_NOP;
        b.cmp_ctrl = CMP_EQ;
        return b;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: classifies the instruction format from the opcode and
// builds the sign-extended immediate for it.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [2:0]      fmt_c,
    output logic [XLEN-1:0] imm_c
);

    imm_fmt_t fmt_sel;

    always_comb begin
        fmt_sel = FMT_NONE;
        case (instr[6:0])
            OPC_OP_IMM, OPC_JALR, OPC_LOAD: fmt_sel = FMT_I;
            OPC_STORE:                      fmt_sel = FMT_S;
            OPC_BRANCH:                     fmt_sel = FMT_B;
            OPC_LUI, OPC_AUIPC:             fmt_sel = FMT_U;
            OPC_JAL:                        fmt_sel = FMT_J;
            default:                        fmt_sel = FMT_NONE;
        endcase
    end

    always_comb begin
        imm_c = '0;
        case (fmt_sel)
            FMT_I:   imm_c = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm_c = {instr[31:12], 12'b0};
            FMT_J:   imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end

    assign fmt_c = fmt_sel;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes {instr, pc} into the EX control bundle and holds
// it in a single-entry pipeline register with stall and flush.
module decode_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_alu_ctrl,
    output logic [2:0]      out_cmp_ctrl,
    output logic [1:0]      out_src_a_sel,
    output logic [1:0]      out_src_b_sel,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_reg_we,
    output logic            out_cmp_to_rd,
    output logic            out_mem_re,
    output logic            out_mem_we,
    output logic [2:0]      out_mem_funct3,
    output logic            out_is_branch,
    output logic            out_is_jal,
    output logic            out_is_jalr,
    output logic            out_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      imm_fmt;
    logic [XLEN-1:0] imm_val;
    arith_t          ar;
    logic            alt, legal, uses_rs1, uses_rs2, writes_rd;
    decode_bundle_t  dec;
    decode_bundle_t  bundle_q;
    logic            valid_q;
    logic            accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    imm_gen u_imm_gen (
        .instr (in_instr),
        .fmt_c (imm_fmt),
        .imm_c (imm_val)
    );

    always_comb begin
        dec           = '0;
        dec.pc        = in_pc;
        dec.alu_ctrl  = ALU_NOP;
        dec.cmp_ctrl  = CMP_EQ;
        legal         = 1'b1;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        writes_rd     = 1'b0;
        alt           = (opcode == OPC_OP && funct7[5]) ||
                        (opcode == OPC_OP_IMM && funct3 == 3'b101 && funct7[5]);
        ar            = arith_map(funct3, alt);
        case (opcode)
            OPC_OP: begin
                legal = (funct7 == 7'h00) ||
                        (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
                {uses_rs1, uses_rs2, writes_rd} = 3'b111;
                dec.alu_ctrl  = ar.alu;
                dec.cmp_ctrl  = ar.cmp;
                dec.cmp_to_rd = ar.cmp_to_rd;
            end
            OPC_OP_IMM: begin
                // shift-immediates carry funct7 in imm[11:5]
                if (funct3 == 3'b001)
                    legal = (funct7 == 7'h00);
                else if (funct3 == 3'b101)
                    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
                {uses_rs1, writes_rd} = 2'b11;
                dec.alu_ctrl  = ar.alu;
                dec.cmp_ctrl  = ar.cmp;
                dec.cmp_to_rd = ar.cmp_to_rd;
                dec.src_b_sel = SRC_B_IMM;
            end
            OPC_LUI, OPC_AUIPC: begin
                writes_rd     = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
                dec.src_a_sel = (opcode == OPC_LUI) ? SRC_A_ZERO : SRC_A_PC;
                dec.src_b_sel = SRC_B_IMM;
            end
            OPC_JAL, OPC_JALR: begin
                legal         = (opcode == OPC_JAL) || (funct3 == 3'b000);
                uses_rs1      = (opcode == OPC_JALR);
                writes_rd     = 1'b1;
                dec.alu_ctrl  = ALU_ADD;
                dec.src_a_sel = SRC_A_PC;
                dec.src_b_sel = SRC_B_FOUR;
                dec.is_jal    = (opcode == OPC_JAL);
                dec.is_jalr   = (opcode == OPC_JALR);
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000:  dec.cmp_ctrl = CMP_EQ;
                    3'b001:  dec.cmp_ctrl = CMP_NEQ;
                    3'b100:  dec.cmp_ctrl = CMP_LT;
                    3'b101:  dec.cmp_ctrl = CMP_GE;
                    3'b110:  dec.cmp_ctrl = CMP_LTU;
                    3'b111:  dec.cmp_ctrl = CMP_GEU;
                    default: legal = 1'b0;
                endcase
                {uses_rs1, uses_rs2} = 2'b11;
                dec.alu_ctrl  = ALU_ADD;
                dec.src_a_sel = SRC_A_PC;
                dec.src_b_sel = SRC_B_IMM;
                dec.is_branch = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
                if (opcode == OPC_LOAD)
                    legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
                else
                    legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
                uses_rs1       = 1'b1;
                uses_rs2       = (opcode == OPC_STORE);
                writes_rd      = (opcode == OPC_LOAD);
                dec.alu_ctrl   = ALU_ADD;
                dec.src_b_sel  = SRC_B_IMM;
                dec.mem_re     = (opcode == OPC_LOAD);
                dec.mem_we     = (opcode == OPC_STORE);
                dec.mem_funct3 = funct3;
            end
            default: legal = 1'b0;
        endcase
        if (in_instr[1:0] != 2'b11)
            legal = 1'b0;
        dec.imm    = (imm_fmt_t'(imm_fmt) == FMT_NONE) ? '0 : imm_val;
        dec.rs1    = uses_rs1  ? in_instr[19:15] : 5'd0;
        dec.rs2    = uses_rs2  ? in_instr[24:20] : 5'd0;
        dec.rd     = writes_rd ? in_instr[11:7]  : 5'd0;
        dec.reg_we = writes_rd && (in_instr[11:7] != 5'd0);
        // illegal encodings still flow downstream, but with every side effect off
        if (!legal) begin
            dec         = reset_bundle();
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // flush outranks accept; a drained register with no new accept goes empty
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q  <= 1'b0;
            bundle_q <= reset_bundle();
        end else if (flush) begin
            valid_q  <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            bundle_q <= dec;
        end else if (out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    assign out_valid      = valid_q;
    assign out_pc         = bundle_q.pc;
    assign out_alu_ctrl   = bundle_q.alu_ctrl;
    assign out_cmp_ctrl   = bundle_q.cmp_ctrl;
    assign out_src_a_sel  = bundle_q.src_a_sel;
    assign out_src_b_sel  = bundle_q.src_b_sel;
    assign out_rs1        = bundle_q.rs1;
    assign out_rs2        = bundle_q.rs2;
    assign out_rd         = bundle_q.rd;
    assign out_imm        = bundle_q.imm;
    assign out_reg_we     = bundle_q.reg_we;
    assign out_cmp_to_rd  = bundle_q.cmp_to_rd;
    assign out_mem_re     = bundle_q.mem_re;
    assign out_mem_we     = bundle_q.mem_we;
    assign out_mem_funct3 = bundle_q.mem_funct3;
    assign out_is_branch  = bundle_q.is_branch;
    assign out_is_jal     = bundle_q.is_jal;
    assign out_is_jalr    = bundle_q.is_jalr;
    assign out_illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected bundles are queued when an accept
// is predicted and compared against out_* once the stage presents them.
module tb_decode_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rstn, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [3:0]  out_alu_ctrl;
    logic [2:0]  out_cmp_ctrl, out_mem_funct3;
    logic [1:0]  out_src_a_sel, out_src_b_sel;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_reg_we, out_cmp_to_rd, out_mem_re, out_mem_we;
    logic        out_is_branch, out_is_jal, out_is_jalr, out_illegal;

    typedef struct {
        decode_bundle_t b;
        bit             partial;
    } exp_t;

    exp_t           sb[$];
    exp_t           nxt;
    decode_bundle_t e;
    int             checks = 0;
    int             passed = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_alu_ctrl(out_alu_ctrl), .out_cmp_ctrl(out_cmp_ctrl),
        .out_src_a_sel(out_src_a_sel), .out_src_b_sel(out_src_b_sel),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_reg_we(out_reg_we), .out_cmp_to_rd(out_cmp_to_rd), .out_mem_re(out_mem_re),
        .out_mem_we(out_mem_we), .out_mem_funct3(out_mem_funct3), .out_is_branch(out_is_branch),
        .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr), .out_illegal(out_illegal)
    );

    function automatic decode_bundle_t observe();
        decode_bundle_t o;
        o.pc = out_pc;  o.alu_ctrl = alu_op_t'(out_alu_ctrl);  o.cmp_ctrl = cmp_op_t'(out_cmp_ctrl);
        o.src_a_sel = src_a_t'(out_src_a_sel);  o.src_b_sel = src_b_t'(out_src_b_sel);
        o.rs1 = out_rs1;  o.rs2 = out_rs2;  o.rd = out_rd;  o.imm = out_imm;
        o.reg_we = out_reg_we;  o.cmp_to_rd = out_cmp_to_rd;  o.mem_re = out_mem_re;
        o.mem_we = out_mem_we;  o.mem_funct3 = out_mem_funct3;  o.is_branch = out_is_branch;
        o.is_jal = out_is_jal;  o.is_jalr = out_is_jalr;  o.illegal = out_illegal;
        return o;
    endfunction

    function automatic logic [10:0] ctl(decode_bundle_t b);
        return {b.illegal, b.alu_ctrl, b.reg_we, b.mem_re, b.mem_we, b.is_branch, b.is_jal, b.is_jalr};
    endfunction

    function automatic decode_bundle_t mk(logic [31:0] pc, alu_op_t alu, cmp_op_t cmp, src_a_t a,
                                          src_b_t b, logic [4:0] rs1, logic [4:0] rs2,
                                          logic [4:0] rd, logic [31:0] imm, logic we);
        decode_bundle_t r;
        r = '0;
        r.pc = pc;  r.alu_ctrl = alu;  r.cmp_ctrl = cmp;  r.src_a_sel = a;  r.src_b_sel = b;
        r.rs1 = rs1;  r.rs2 = rs2;  r.rd = rd;  r.imm = imm;  r.reg_we = we;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle(input string tag);
        bit acc;
        #1;
        chk({tag, " in_ready"}, 128'(in_ready), 128'((sb.size() == 0) || out_ready));
        acc = in_valid && ((sb.size() == 0) || out_ready);
        if (flush) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && out_ready) void'(sb.pop_front());
            if (acc) sb.push_back(nxt);
        end
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 128'(out_valid), 128'(sb.size() != 0));
        if (sb.size() != 0) begin
            if (sb[0].partial)
                chk({tag, " ctl"}, 128'(ctl(observe())), 128'(ctl(sb[0].b)));
            else
                chk({tag, " bundle"}, 128'(observe()), 128'(sb[0].b));
        end
    endtask

    task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input decode_bundle_t exp, input bit partial);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        nxt      = '{b: exp, partial: partial};
        cycle(tag);
    endtask

    initial begin
        rstn = 1'b0;  flush = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
        in_instr = '0;  in_pc = '0;
        #12;
        chk("reset out_valid", 128'(out_valid), 128'(0));
        chk("reset bundle", 128'(observe()), 128'(mk(0, ALU_NOP, CMP_EQ, SRC_A_RS1, SRC_B_RS2, 0, 0, 0, 0, 0)));
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back decode of each instruction class
        e = mk(32'h100, ALU_ADD, CMP_EQ, SRC_A_RS1, SRC_B_RS2, 1, 2, 3, 0, 1);
        issue("add", 32'h002081B3, 32'h100, e, 0);
        e = mk(32'h104, ALU_SRA, CMP_EQ, SRC_A_RS1, SRC_B_IMM, 6, 0, 5, 32'h403, 1);
        issue("srai", 32'h40335293, 32'h104, e, 0);
        e = mk(32'h108, ALU_NOP, CMP_LTU, SRC_A_RS1, SRC_B_RS2, 2, 3, 1, 0, 1);
        e.cmp_to_rd = 1'b1;
        issue("sltu", 32'h003130B3, 32'h108, e, 0);
        e = mk(32'h10C, ALU_ADD, CMP_LT, SRC_A_PC, SRC_B_IMM, 1, 2, 0, 32'hFFFFFFF8, 0);
        e.is_branch = 1'b1;
        issue("blt", 32'hFE20CCE3, 32'h10C, e, 0);
        e = mk(32'h110, ALU_ADD, CMP_EQ, SRC_A_ZERO, SRC_B_IMM, 0, 0, 7, 32'h12345000, 1);
        issue("lui", 32'h123453B7, 32'h110, e, 0);
        e = mk(32'h114, ALU_ADD, CMP_EQ, SRC_A_PC, SRC_B_FOUR, 0, 0, 1, 32'd16, 1);
        e.is_jal = 1'b1;
        issue("jal", 32'h010000EF, 32'h114, e, 0);
        e = mk(32'h118, ALU_ADD, CMP_EQ, SRC_A_RS1, SRC_B_IMM, 2, 0, 4, 32'hFFFFFFFC, 1);
        e.mem_re = 1'b1;  e.mem_funct3 = 3'd2;
        issue("lw", 32'hFFC12203, 32'h118, e, 0);
        e = mk(32'h11C, ALU_ADD, CMP_EQ, SRC_A_RS1, SRC_B_IMM, 2, 5, 0, 32'd8, 0);
        e.mem_we = 1'b1;  e.mem_funct3 = 3'd2;
        issue("sw", 32'h00512423, 32'h11C, e, 0);
        e = mk(32'h120, ALU_ADD, CMP_EQ, SRC_A_RS1, SRC_B_IMM, 0, 0, 0, 0, 0);
        issue("addi x0", 32'h00000013, 32'h120, e, 0);
        e = mk(32'h124, ALU_SUB, CMP_EQ, SRC_A_RS1, SRC_B_RS2, 1, 2, 3, 0, 1);
        issue("sub", 32'h402081B3, 32'h124, e, 0);

        // illegal encodings: only the control/enable view is pinned down
        e = mk(32'h128, ALU_NOP, CMP_EQ, SRC_A_RS1, SRC_B_RS2, 0, 0, 0, 0, 0);
        e.illegal = 1'b1;
        issue("ill ones", 32'hFFFFFFFF, 32'h128, e, 1);
        e.pc = 32'h12C;
        issue("ill br010", 32'h00002063, 32'h12C, e, 1);
        e.pc = 32'h130;
        issue("ill srli", 32'h02035293, 32'h130, e, 1);

        // stall: held bundle stays bit-stable, no accept until EX drains
        e = mk(32'h134, ALU_ADD, CMP_EQ, SRC_A_PC, SRC_B_IMM, 0, 0, 10, 32'h1000, 1);
        issue("auipc", 32'h00001517, 32'h134, e, 0);
        out_ready = 1'b0;
        e = mk(32'h138, ALU_ADD, CMP_EQ, SRC_A_RS1, SRC_B_RS2, 1, 2, 3, 0, 1);
        for (int i = 0; i < 3; i++) issue("stall", 32'h002081B3, 32'h138, e, 0);
        out_ready = 1'b1;
        issue("release", 32'h002081B3, 32'h138, e, 0);

        // flush kills a held bundle, then an incoming one
        out_ready = 1'b0;
        flush     = 1'b1;
        issue("flush held", 32'h402081B3, 32'h13C, e, 0);
        flush     = 1'b0;
        e = mk(32'h140, ALU_SUB, CMP_EQ, SRC_A_RS1, SRC_B_RS2, 1, 2, 3, 0, 1);
        issue("refill", 32'h402081B3, 32'h140, e, 0);
        out_ready = 1'b1;
        flush     = 1'b1;
        issue("flush incoming", 32'h002081B3, 32'h144, e, 0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        cycle("post flush idle");

        // asynchronous reset mid-stream
        e = mk(32'h148, ALU_NOP, CMP_LTU, SRC_A_RS1, SRC_B_RS2, 2, 3, 1, 0, 1);
        e.cmp_to_rd = 1'b1;
        issue("pre reset", 32'h003130B3, 32'h148, e, 0);
        in_valid = 1'b0;
        rstn     = 1'b0;
        #1;
        chk("async reset out_valid", 128'(out_valid), 128'(0));
        chk("async reset bundle", 128'(observe()), 128'(mk(0, ALU_NOP, CMP_EQ, SRC_A_RS1, SRC_B_RS2, 0, 0, 0, 0, 0)));
        sb.delete();
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        cycle("after reset idle");
        e = mk(32'h200, ALU_ADD, CMP_EQ, SRC_A_RS1, SRC_B_RS2, 1, 2, 3, 0, 1);
        issue("after reset add", 32'h002081B3, 32'h200, e, 0);
        in_valid = 1'b0;
        cycle("drain");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
